// File: rtl/tx_arb_mux.sv
// Packet-aware round-robin AXI4-Stream arbiter feeding the PCIe core TX port.
// One source owns the port per packet; overlong packets are cut, discontinued and drained.
module tx_arb_mux #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MAX_BEATS = 64
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     s_axis_tx_tready,
  output logic [DATA_W-1:0]        s_axis_tx_tdata,
  output logic [KEEP_W-1:0]        s_axis_tx_tkeep,
  output logic                     s_axis_tx_tlast,
  output logic                     s_axis_tx_tvalid,
  output logic                     tx_src_dsc,
  input  logic [N_CH*DATA_W-1:0]   ch_tdata,
  input  logic [N_CH*KEEP_W-1:0]   ch_tkeep,
  input  logic [N_CH-1:0]          ch_tlast,
  input  logic [N_CH-1:0]          ch_tvalid,
  input  logic [N_CH-1:0]          ch_src_dsc,
  output logic [N_CH-1:0]          ch_tready,
  output logic [N_CH-1:0]          ch_gnt,
  output logic                     busy,
  output logic                     trunc_pulse
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               trunc_pulse_q, trunc_pulse_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;

  logic [DATA_W-1:0]  g_data;
  logic [KEEP_W-1:0]  g_keep;
  logic               g_last, g_valid, g_dsc;
  logic               accept, last_slot, trunc_beat;
  logic [IDX_W-1:0]   next_ptr;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_CH;
      if (!win_found && ch_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign g_data     = ch_tdata[gidx_q*DATA_W +: DATA_W];
  assign g_keep     = ch_tkeep[gidx_q*KEEP_W +: KEEP_W];
  assign g_last     = ch_tlast[gidx_q];
  assign g_valid    = ch_tvalid[gidx_q];
  assign g_dsc      = ch_src_dsc[gidx_q];
  assign accept     = g_valid && s_axis_tx_tready;
  assign last_slot  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  // A beat carrying its own tlast in the final slot is a legal full-length packet.
  assign trunc_beat = last_slot && !g_last;
  assign next_ptr   = (int'(gidx_q) == N_CH - 1) ? '0 : gidx_q + 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d          = state_q;
    gnt_d            = gnt_q;
    gidx_d           = gidx_q;
    rr_ptr_d         = rr_ptr_q;
    beat_cnt_d       = beat_cnt_q;
    trunc_pulse_d    = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    tx_src_dsc       = 1'b0;
    ch_tready        = '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = N_CH'(1) << win_idx;
          gidx_d     = win_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end

      GRANT: begin
        s_axis_tx_tdata   = g_data;
        s_axis_tx_tkeep   = g_keep;
        s_axis_tx_tvalid  = g_valid;
        s_axis_tx_tlast   = g_last || trunc_beat;
        tx_src_dsc        = g_dsc || trunc_beat;
        ch_tready[gidx_q] = s_axis_tx_tready;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last) begin
            rr_ptr_d = next_ptr;
            gnt_d    = '0;
            state_d  = IDLE;
          end else if (last_slot) begin
            trunc_pulse_d = 1'b1;
            state_d       = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Swallow the rest of the cut packet; the core already saw its discontinue.
        ch_tready[gidx_q] = 1'b1;
        if (g_valid && g_last) begin
          rr_ptr_d = next_ptr;
          gnt_d    = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; only these control registers are reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      trunc_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      trunc_pulse_q <= trunc_pulse_d;
    end
  end

  assign ch_gnt      = gnt_q;
  assign busy        = (state_q != IDLE);
  assign trunc_pulse = trunc_pulse_q;

endmodule

// File: tb/tb_tx_arb_mux.sv
// Bench for tx_arb_mux: cycle vector table, packet-source scenarios and a randomized run
// checked against a packet-level round-robin model of the merged output stream.
module tb_tx_arb_mux;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 64;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int MAX_BEATS = 4;
  localparam int MAX_PK    = 16;
  localparam int BUDGET    = 5000;

  logic                   clk = 1'b0;
  logic                   sys_rst_n;
  logic                   s_axis_tx_tready;
  logic [DATA_W-1:0]      s_axis_tx_tdata;
  logic [KEEP_W-1:0]      s_axis_tx_tkeep;
  logic                   s_axis_tx_tlast;
  logic                   s_axis_tx_tvalid;
  logic                   tx_src_dsc;
  logic [N_CH*DATA_W-1:0] ch_tdata;
  logic [N_CH*KEEP_W-1:0] ch_tkeep;
  logic [N_CH-1:0]        ch_tlast;
  logic [N_CH-1:0]        ch_tvalid;
  logic [N_CH-1:0]        ch_src_dsc;
  logic [N_CH-1:0]        ch_tready;
  logic [N_CH-1:0]        ch_gnt;
  logic                   busy;
  logic                   trunc_pulse;

  tx_arb_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .s_axis_tx_tready(s_axis_tx_tready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .tx_src_dsc(tx_src_dsc), .ch_tdata(ch_tdata), .ch_tkeep(ch_tkeep),
    .ch_tlast(ch_tlast), .ch_tvalid(ch_tvalid), .ch_src_dsc(ch_src_dsc),
    .ch_tready(ch_tready), .ch_gnt(ch_gnt), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle vector table ----------------
  typedef struct packed {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        sdsc;
    logic        rdy;
    logic [7:0]  dat;
    logic        e_vld;
    logic        e_last;
    logic        e_dsc;
    logic [15:0] e_data;
    logic [3:0]  e_gnt;
    logic [3:0]  e_crdy;
    logic        e_busy;
    logic        e_trunc;
  } vec_t;

  function automatic vec_t mk(logic [3:0] vld, logic [3:0] last, logic sdsc, logic rdy,
                              logic [7:0] dat, logic e_vld, logic e_last, logic e_dsc,
                              logic [15:0] e_data, logic [3:0] e_gnt, logic [3:0] e_crdy,
                              logic e_busy, logic e_trunc);
    vec_t v;
    v.vld = vld; v.last = last; v.sdsc = sdsc; v.rdy = rdy; v.dat = dat;
    v.e_vld = e_vld; v.e_last = e_last; v.e_dsc = e_dsc; v.e_data = e_data;
    v.e_gnt = e_gnt; v.e_crdy = e_crdy; v.e_busy = e_busy; v.e_trunc = e_trunc;
    return v;
  endfunction

  // ---------------- packet sources and output model ----------------
  typedef struct packed {
    logic [3:0]        gnt;
    logic              last;
    logic              dsc;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t           exp_q[$];
  beat_t           obs_q[$];
  int              obs_cyc[$];
  int              plen[N_CH][MAX_PK];
  int              npk[N_CH];
  int              cur_pkt[N_CH];
  int              cur_beat[N_CH];
  logic [N_CH-1:0] acc;
  int              cyc, n_trunc_obs, n_trunc_exp, model_rr;
  logic            prev_stall;
  beat_t           prev_out;

  function automatic logic [DATA_W-1:0] beat_data(int c, int k, int b);
    return {40'h0, 8'(c), 8'(k), 8'(b)};
  endfunction

  task automatic clear_src();
    for (int i = 0; i < N_CH; i++) begin
      npk[i] = 0; cur_pkt[i] = 0; cur_beat[i] = 0;
    end
    acc = '0;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N_CH; i++) begin
      if (cur_pkt[i] < npk[i]) begin
        ch_tvalid[i] = 1'b1;
        ch_tlast[i]  = (cur_beat[i] == plen[i][cur_pkt[i]] - 1);
        ch_tdata[i*DATA_W +: DATA_W] = beat_data(i, cur_pkt[i], cur_beat[i]);
      end else begin
        ch_tvalid[i] = 1'b0;
        ch_tlast[i]  = 1'b0;
        ch_tdata[i*DATA_W +: DATA_W] = '0;
      end
    end
    ch_tkeep   = '1;
    ch_src_dsc = '0;
  endtask

  function automatic bit src_done();
    for (int i = 0; i < N_CH; i++)
      if (cur_pkt[i] < npk[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Expected TX stream: whole packets in round-robin order among channels with
  // packets pending, each cut to MAX_BEATS with the cut beat marked last+discontinue.
  task automatic build_expected();
    int    nxt[N_CH];
    int    ptr, pick, len, n;
    beat_t e;
    exp_q.delete();
    n_trunc_exp = 0;
    ptr = model_rr;
    for (int i = 0; i < N_CH; i++) nxt[i] = 0;
    for (int guard = 0; guard < N_CH * MAX_PK; guard++) begin
      pick = -1;
      for (int off = 0; off < N_CH; off++)
        if (pick < 0 && nxt[(ptr + off) % N_CH] < npk[(ptr + off) % N_CH])
          pick = (ptr + off) % N_CH;
      if (pick < 0) break;
      len = plen[pick][nxt[pick]];
      n   = (len > MAX_BEATS) ? MAX_BEATS : len;
      for (int b = 0; b < n; b++) begin
        e.gnt  = 4'(1 << pick);
        e.last = (b == n - 1);
        e.dsc  = (len > MAX_BEATS) && (b == n - 1);
        e.data = beat_data(pick, nxt[pick], b);
        exp_q.push_back(e);
      end
      if (len > MAX_BEATS) n_trunc_exp++;
      nxt[pick]++;
      ptr = (pick + 1) % N_CH;
    end
    model_rr = ptr;
  endtask

  task automatic step(input logic rdy);
    beat_t cur;
    @(posedge clk); #1;
    for (int i = 0; i < N_CH; i++) begin
      if (acc[i]) begin
        cur_beat[i]++;
        if (cur_beat[i] == plen[i][cur_pkt[i]]) begin
          cur_beat[i] = 0;
          cur_pkt[i]++;
        end
      end
    end
    drive_src();
    s_axis_tx_tready = rdy;
    @(negedge clk);
    cyc++;
    acc = ch_tvalid & ch_tready;
    cur.gnt  = ch_gnt;
    cur.last = s_axis_tx_tlast;
    cur.dsc  = tx_src_dsc;
    cur.data = s_axis_tx_tdata;
    if (s_axis_tx_tvalid && s_axis_tx_tready) begin
      obs_q.push_back(cur);
      obs_cyc.push_back(cyc);
    end
    if (trunc_pulse) n_trunc_obs++;
    if (prev_stall) check("stall_hold", {s_axis_tx_tvalid, cur}, {1'b1, prev_out});
    check("crdy_only_granted", ch_tready & ~ch_gnt, '0);
    if (s_axis_tx_tvalid) check("crdy_mirror", ch_tready, ch_gnt & {N_CH{s_axis_tx_tready}});
    prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
    prev_out   = cur;
  endtask

  // mode 0: always ready, 1: random ready, 2: fixed backpressure pattern
  task automatic run_src(input int mode, input bit check_gap, input string tag);
    logic [7:0] pat;
    logic       rdy;
    int         n;
    pat = 8'b1011_0011;
    build_expected();
    obs_q.delete();
    obs_cyc.delete();
    cyc = 0;
    n_trunc_obs = 0;
    prev_stall = 1'b0;
    while (!(src_done() && obs_q.size() >= exp_q.size()) && cyc < BUDGET) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else                rdy = (cyc < 8) ? pat[cyc] : 1'b1;
      step(rdy);
    end
    if (cyc >= BUDGET) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: run still active after %0d cycles", tag, cyc);
    end
    check({tag, "_beat_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_beat"}, obs_q[i], exp_q[i]);
    check({tag, "_trunc_count"}, n_trunc_obs, n_trunc_exp);
    if (check_gap)
      for (int i = 1; i < n; i++)
        if (obs_q[i-1].last) check({tag, "_idle_gap"}, obs_cyc[i] - obs_cyc[i-1], 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[22];
    vecs[0]  = mk(4'b0010, 4'b0000, 0, 1, 8'hA0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(4'b0010, 4'b0000, 0, 1, 8'hA0, 1, 0, 0, 16'h01A0, 4'b0010, 4'b0010, 1, 0);
    vecs[2]  = mk(4'b0010, 4'b0000, 0, 1, 8'hA1, 1, 0, 0, 16'h01A1, 4'b0010, 4'b0010, 1, 0);
    vecs[3]  = mk(4'b0010, 4'b0010, 0, 1, 8'hA2, 1, 1, 0, 16'h01A2, 4'b0010, 4'b0010, 1, 0);
    vecs[4]  = mk(4'b0000, 4'b0000, 0, 1, 8'h00, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    // rr_ptr is now 2: ch0 wins over ch1; 7-beat packet cut at beat 4
    vecs[5]  = mk(4'b0011, 4'b0000, 0, 1, 8'hB1, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    vecs[6]  = mk(4'b0011, 4'b0000, 0, 1, 8'hB1, 1, 0, 0, 16'h00B1, 4'b0001, 4'b0001, 1, 0);
    vecs[7]  = mk(4'b0011, 4'b0000, 1, 1, 8'hB2, 1, 0, 1, 16'h00B2, 4'b0001, 4'b0001, 1, 0);
    vecs[8]  = mk(4'b0011, 4'b0000, 0, 1, 8'hB3, 1, 0, 0, 16'h00B3, 4'b0001, 4'b0001, 1, 0);
    vecs[9]  = mk(4'b0011, 4'b0000, 0, 1, 8'hB4, 1, 1, 1, 16'h00B4, 4'b0001, 4'b0001, 1, 0);
    vecs[10] = mk(4'b0011, 4'b0000, 0, 1, 8'hB5, 0, 0, 0, 16'h0000, 4'b0001, 4'b0001, 1, 1);
    vecs[11] = mk(4'b0011, 4'b0000, 0, 0, 8'hB6, 0, 0, 0, 16'h0000, 4'b0001, 4'b0001, 1, 0);
    vecs[12] = mk(4'b0011, 4'b0001, 0, 1, 8'hB7, 0, 0, 0, 16'h0000, 4'b0001, 4'b0001, 1, 0);
    vecs[13] = mk(4'b0010, 4'b0000, 0, 1, 8'hC0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    vecs[14] = mk(4'b0010, 4'b0010, 0, 1, 8'hC0, 1, 1, 0, 16'h01C0, 4'b0010, 4'b0010, 1, 0);
    vecs[15] = mk(4'b0000, 4'b0000, 0, 1, 8'h00, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    // exactly MAX_BEATS beats with tlast on the last one: no cut
    vecs[16] = mk(4'b0100, 4'b0000, 0, 1, 8'hD0, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);
    vecs[17] = mk(4'b0100, 4'b0000, 0, 1, 8'hD0, 1, 0, 0, 16'h02D0, 4'b0100, 4'b0100, 1, 0);
    vecs[18] = mk(4'b0100, 4'b0000, 0, 1, 8'hD1, 1, 0, 0, 16'h02D1, 4'b0100, 4'b0100, 1, 0);
    vecs[19] = mk(4'b0100, 4'b0000, 0, 1, 8'hD2, 1, 0, 0, 16'h02D2, 4'b0100, 4'b0100, 1, 0);
    vecs[20] = mk(4'b0100, 4'b0100, 0, 1, 8'hD3, 1, 1, 0, 16'h02D3, 4'b0100, 4'b0100, 1, 0);
    vecs[21] = mk(4'b0000, 4'b0000, 0, 1, 8'h00, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0);

    // Reset, with requests present to show nothing is granted while held.
    sys_rst_n = 1'b0;
    s_axis_tx_tready = 1'b1;
    ch_tdata = '0; ch_tkeep = '1; ch_tlast = '0; ch_src_dsc = '0;
    ch_tvalid = '1;
    clear_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", s_axis_tx_tvalid, 1'b0);
    check("reset_tx_bus", {s_axis_tx_tlast, tx_src_dsc, s_axis_tx_tkeep, s_axis_tx_tdata}, '0);
    check("reset_gnt_rdy", {ch_gnt, ch_tready}, '0);
    check("reset_busy_trunc", {busy, trunc_pulse}, '0);
    ch_tvalid = '0;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      ch_tvalid = vecs[i].vld;
      ch_tlast  = vecs[i].last;
      ch_src_dsc = {N_CH{vecs[i].sdsc}};
      s_axis_tx_tready = vecs[i].rdy;
      for (int c = 0; c < N_CH; c++) ch_tdata[c*DATA_W +: DATA_W] = {48'h0, 8'(c), vecs[i].dat};
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), s_axis_tx_tvalid, vecs[i].e_vld);
      check($sformatf("vec%0d_last_dsc", i), {s_axis_tx_tlast, tx_src_dsc}, {vecs[i].e_last, vecs[i].e_dsc});
      if (vecs[i].e_vld) check($sformatf("vec%0d_data", i), s_axis_tx_tdata, {48'h0, vecs[i].e_data});
      check($sformatf("vec%0d_gnt", i), ch_gnt, vecs[i].e_gnt);
      check($sformatf("vec%0d_ch_tready", i), ch_tready, vecs[i].e_crdy);
      check($sformatf("vec%0d_busy_trunc", i), {busy, trunc_pulse}, {vecs[i].e_busy, vecs[i].e_trunc});
    end
    model_rr = 3;

    // Round-robin among ch0, ch2, ch3 with 2-beat packets.
    clear_src();
    plen[0][0] = 2; plen[0][1] = 2; npk[0] = 2;
    plen[2][0] = 2; plen[2][1] = 2; npk[2] = 2;
    plen[3][0] = 2; plen[3][1] = 2; npk[3] = 2;
    run_src(0, 1'b1, "rr");

    // Backpressure on a 4-beat ch2 packet.
    clear_src();
    plen[2][0] = 4; npk[2] = 1;
    run_src(2, 1'b0, "bp");

    // Reset during beat 2 of a 5-beat ch1 packet.
    clear_src();
    plen[1][0] = 5; npk[1] = 1;
    prev_stall = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    check("pre_reset_beat2", {s_axis_tx_tvalid, s_axis_tx_tdata}, {1'b1, beat_data(1, 0, 1)});
    #2 sys_rst_n = 1'b0;
    #1;
    check("midpkt_reset_tx", {s_axis_tx_tvalid, s_axis_tx_tlast, tx_src_dsc, s_axis_tx_tdata}, '0);
    check("midpkt_reset_gnt_rdy", {ch_gnt, ch_tready, busy}, '0);
    clear_src();
    drive_src();
    @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_rr = 0;
    plen[0][0] = 1; npk[0] = 1;
    plen[3][0] = 1; npk[3] = 1;
    run_src(0, 1'b1, "post_reset");

    // Randomized traffic on all channels with random backpressure.
    clear_src();
    for (int c = 0; c < N_CH; c++) begin
      npk[c] = 10;
      for (int k = 0; k < 10; k++) plen[c][k] = $urandom_range(1, 7);
    end
    run_src(1, 1'b0, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arb_mux.md
Name: tx_arb_mux

Overview:
- Packet-aware N-channel AXI4-Stream arbiter that merges several TLP sources onto the single PCIe core TX interface (s_axis_tx_*).
- Grants one source per packet, rotating round-robin between packets. The grant is held until tlast.
- Enforces a maximum packet length; an overlong packet is truncated, discontinued via tx_src_dsc, and its remainder drained.
- Sits between TLP generators (DMA, completion, message engines) and the PCIe endpoint TX port.

Parameters:
- N_CH, 4, number of input channels (2..8).
- DATA_W, 64, stream data width in bits (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width.
- MAX_BEATS, 64, maximum beats per packet; the beat counter is clog2(MAX_BEATS+1) bits wide.

Ports:
- clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- s_axis_tx_tready  in  1  PCIe core ready.
- s_axis_tx_tdata  out  DATA_W  merged data.
- s_axis_tx_tkeep  out  KEEP_W  merged keep.
- s_axis_tx_tlast  out  1  merged last.
- s_axis_tx_tvalid  out  1  merged valid.
- tx_src_dsc  out  1  discontinue to the core.
- ch_tdata  in  N_CH*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_tkeep  in  N_CH*KEEP_W  channel keep.
- ch_tlast  in  N_CH  channel last.
- ch_tvalid  in  N_CH  channel valid; also serves as the arbitration request.
- ch_src_dsc  in  N_CH  channel discontinue.
- ch_tready  out  N_CH  per-channel ready.
- ch_gnt  out  N_CH  one-hot current grant (zero when idle).
- busy  out  1  high in GRANT or DRAIN.
- trunc_pulse  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Asynchronous active-low reset on sys_rst_n forces:
  - state=IDLE, ch_gnt=0, rr_ptr=0, beat_cnt=0, trunc_pulse=0;
  - all outputs low.
- States:
  - IDLE:
    - s_axis_tx_tvalid=0, ch_tready=0.
    - If any ch_tvalid is set, select the first set bit searching from rr_ptr upward with wrap.
    - Next edge: ch_gnt=onehot(winner), beat_cnt=0, go to GRANT.
    - Arbitration costs exactly one idle cycle per packet.
  - GRANT (channel g):
    - Datapath is combinational: s_axis_tx_{tdata,tkeep,tlast,tvalid}=ch_*[g].
    - tx_src_dsc=ch_src_dsc[g].
    - ch_tready[g]=s_axis_tx_tready; all other ch_tready=0. Non-granted channels are never consumed.
    - An accepted beat is tvalid&tready; each one increments beat_cnt.
    - Accepted beat with tlast: rr_ptr=(g+1) mod N_CH, ch_gnt=0, go to IDLE.
    - Accepted beat that is number MAX_BEATS (beat_cnt==MAX_BEATS-1) while ch_tlast[g]=0:
      - on that beat force s_axis_tx_tlast=1 and tx_src_dsc=1;
      - assert trunc_pulse next cycle;
      - go to DRAIN.
    - A beat with tlast=1 on exactly beat MAX_BEATS is normal: no truncation.
  - DRAIN (channel g):
    - s_axis_tx_tvalid=0; ch_tready[g]=1; beats are discarded.
    - ch_gnt still shows g.
    - On an accepted beat with tlast: rr_ptr=(g+1) mod N_CH, go to IDLE.
- Output stability: while s_axis_tx_tvalid=1 and s_axis_tx_tready=0, outputs follow channel g. Channels must hold their beat under AXIS rules; the mux introduces no change.
- Grant changes only on a packet boundary or truncation, never mid-packet.
- Single-beat packets are legal: tlast on beat 1.
- Reset mid-packet aborts immediately. The partial packet is not completed on the TX port, and the source sees ch_tready low.
- Channels not at rr_ptr starve for at most N_CH-1 packets.

Test Plan:
- Single channel: ch1 sends 3 beats 0xA0..0xA2 with tready=1.
  - Required: IDLE cycle, then 3 output beats with tlast on 0xA2.
  - ch_gnt=4'b0010 during the packet; rr_ptr=2 afterwards.
- Round-robin: ch0, ch2 and ch3 all valid with 2-beat packets.
  - Required: grant order 0, 2, 3, 0…; no interleaving of beats.
  - The IDLE gap between packets is exactly 1 cycle.
- Backpressure: ch2 sends 4 beats while s_axis_tx_tready toggles 1,0,0,1,1,0,1.
  - Required: output data is stable during tready=0.
  - ch_tready[2] mirrors tready; all other ch_tready stay 0; all 4 beats are delivered in order.
- Truncation: MAX_BEATS=4, ch0 sends 7 beats with tlast on beat 7.
  - Required: beat 4 carries tlast=1 and tx_src_dsc=1; trunc_pulse is high for 1 cycle.
  - Beats 5–7 are consumed with output tvalid=0; the next packet is granted to ch1 if valid.
- Boundary: MAX_BEATS=4, 4-beat packet with tlast on beat 4.
  - Required: no truncation, tx_src_dsc=0, trunc_pulse=0.
- Reset: assert sys_rst_n=0 asynchronously mid-packet on beat 2 of 5.
  - Required: all outputs 0 immediately; ch_gnt=0; after release, arbitration starts from ch0.
